// File: rtl/if_align_buf_if.sv
// Fetch-alignment buffer signal bundle: redirect/stall control, icache request/response, instruction window.
// The master modport is the buffer's view; slave is the surrounding core/icache view.
interface if_align_buf_if;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        icache_req_valid_o;
    logic [31:0] icache_req_addr_o;
    logic        icache_req_ready_i;
    logic        icache_resp_valid_i;
    logic [31:0] icache_resp_data_i;
    logic [31:0] pc_addr_o;
    logic [31:0] inst_o;
    logic        if_rdata_valid_o;
    logic        next_rdata_valid_o;

    modport master (
        input  redirect_valid_i, redirect_pc_i, stall_i,
        input  icache_req_ready_i, icache_resp_valid_i, icache_resp_data_i,
        output icache_req_valid_o, icache_req_addr_o,
        output pc_addr_o, inst_o, if_rdata_valid_o, next_rdata_valid_o
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, stall_i,
        output icache_req_ready_i, icache_resp_valid_i, icache_resp_data_i,
        input  icache_req_valid_o, icache_req_addr_o,
        input  pc_addr_o, inst_o, if_rdata_valid_o, next_rdata_valid_o
    );
endinterface

// File: rtl/if_align_buf.sv
// Two-word fetch alignment buffer presenting a whole RVC/32-bit instruction at the PC; window is valid the cycle
// after the completing response (no bypass); stall_i freezes the window while requests continue until 2 words are held.
module if_align_buf #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst,
    if_align_buf_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]     r_word0, w_word0_nxt;
    logic [31:0]     r_word1, w_word1_nxt;
    logic            r_valid0, w_valid0_nxt;
    logic            r_valid1, w_valid1_nxt;
    logic [1:0]      r_outstanding, w_out_nxt;

    logic [15:0]     w_first_hw;
    logic            w_rvc;
    logic            w_complete;
    logic [2:0]      w_fill;
    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_consume;
    logic            w_pop;
    logic            w_accept;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_redir_fetch;

    assign w_first_hw = r_pc[1] ? r_word0[31:16] : r_word0[15:0];
    assign w_rvc      = (w_first_hw[1:0] != 2'b11);
    assign w_complete = r_valid0 && (w_rvc || !r_pc[1] || r_valid1);

    // Buffered words plus in-flight requests never exceed the two slots.
    assign w_fill     = {2'b00, r_valid0} + {2'b00, r_valid1} + {1'b0, r_outstanding};
    assign w_req_vld  = (r_state == S_RUN) && (w_fill < 3'd2);
    assign w_req_fire = w_req_vld && bus.icache_req_ready_i;

    assign w_consume  = w_complete && !bus.stall_i && !bus.redirect_valid_i;
    assign w_pc_inc   = r_pc + (w_rvc ? XLEN'(2) : XLEN'(4));
    assign w_pop      = w_consume && (w_pc_inc[XLEN-1:2] != r_pc[XLEN-1:2]);
    assign w_accept   = bus.icache_resp_valid_i && !bus.redirect_valid_i && (r_state == S_RUN);

    assign w_redir_pc    = bus.redirect_pc_i & ~XLEN'(1);
    assign w_redir_fetch = bus.redirect_pc_i & ~XLEN'(3);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_word0_nxt    = r_word0;
        w_word1_nxt    = r_word1;
        w_valid0_nxt   = r_valid0;
        w_valid1_nxt   = r_valid1;
        // Every response retires one request, whether kept or dropped as stale.
        w_out_nxt      = r_outstanding + {1'b0, w_req_fire} - {1'b0, bus.icache_resp_valid_i};

        if (w_consume) begin
            w_pc_nxt = w_pc_inc;
        end
        if (w_pop) begin
            w_word0_nxt  = r_word1;
            w_valid0_nxt = r_valid1;
            w_valid1_nxt = 1'b0;
        end
        if (w_accept) begin
            if (!w_valid0_nxt) begin
                w_word0_nxt  = bus.icache_resp_data_i;
                w_valid0_nxt = 1'b1;
            end else begin
                w_word1_nxt  = bus.icache_resp_data_i;
                w_valid1_nxt = 1'b1;
            end
        end
        if (w_req_fire) begin
            w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end

        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            S_DRAIN: w_state_nxt = (w_out_nxt == 2'd0) ? S_RUN : S_DRAIN;
            default: w_state_nxt = S_BOOT;
        endcase

        // A same-cycle handshake is already counted in w_out_nxt, so it drains as stale.
        if (bus.redirect_valid_i) begin
            w_pc_nxt       = w_redir_pc;
            w_fetch_pc_nxt = w_redir_fetch;
            w_valid0_nxt   = 1'b0;
            w_valid1_nxt   = 1'b0;
            w_state_nxt    = (w_out_nxt != 2'd0) ? S_DRAIN : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_word0       <= '0;
            r_word1       <= '0;
            r_valid0      <= 1'b0;
            r_valid1      <= 1'b0;
            r_outstanding <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_word0       <= w_word0_nxt;
            r_word1       <= w_word1_nxt;
            r_valid0      <= w_valid0_nxt;
            r_valid1      <= w_valid1_nxt;
            r_outstanding <= w_out_nxt;
        end
    end

    assign bus.icache_req_valid_o = w_req_vld;
    assign bus.icache_req_addr_o  = r_fetch_pc;
    assign bus.pc_addr_o          = r_pc;
    assign bus.inst_o             = r_pc[1] ? {r_word1[15:0], r_word0[31:16]} : r_word0;
    assign bus.if_rdata_valid_o   = r_valid0;
    assign bus.next_rdata_valid_o = w_complete;

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
        bus.icache_resp_valid_i |-> (r_outstanding != 2'd0));
endmodule

// File: tb/tb_if_align_buf.sv
// Randomized bench: a memory-backed icache responder feeds the buffer, and a scoreboard walks the same memory
// instruction by instruction from each reset/redirect target to predict every consumed (pc, instruction).
module tb_if_align_buf;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rvc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    if_align_buf_if bus ();

    if_align_buf #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    pend_t       pend[$];
    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] model_pc;
    int cyc = 0, n_cmp = 0, n_bad = 0, n_consumed = 0;
    int ready_pct = 100, lat_min = 0, lat_max = 0;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: walk memory one instruction at a time from model_pc.
    function automatic void refill();
        exp_t        e;
        logic [15:0] h0;
        while (exp_q.size() < 16) begin
            h0     = hw(model_pc);
            e.pc   = model_pc;
            e.rvc  = (h0[1:0] != 2'b11);
            e.inst = e.rvc ? {16'h0000, h0} : {hw(model_pc + 32'd2), h0};
            model_pc = model_pc + (e.rvc ? 32'd2 : 32'd4);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc & ~32'h1;
        refill();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // icache model: in-order responses after a random latency, drops everything while in reset
    // and drives a junk response during reset that must never reach the buffer.
    initial begin : responder
        pend_t p;
        bus.icache_resp_valid_i = 1'b0;
        bus.icache_resp_data_i  = '0;
        bus.icache_req_ready_i  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend.delete();
                bus.icache_resp_valid_i = 1'b1;
                bus.icache_resp_data_i  = 32'hDEAD_BEEF;
                bus.icache_req_ready_i  = 1'b1;
            end else begin
                bus.icache_resp_valid_i = 1'b0;
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    p = pend.pop_front();
                    bus.icache_resp_valid_i = 1'b1;
                    bus.icache_resp_data_i  = mem[p.addr[11:2]];
                end
                bus.icache_req_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
                #1;
                if (bus.icache_req_valid_o && bus.icache_req_ready_i) begin
                    p.addr = bus.icache_req_addr_o;
                    p.due  = cyc + 1 + int'($urandom_range(lat_min, lat_max));
                    pend.push_back(p);
                    req_log.push_back(bus.icache_req_addr_o);
                end
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (rst && bus.if_rdata_valid_o && bus.next_rdata_valid_o && !bus.stall_i && !bus.redirect_valid_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc %h with no prediction pending", bus.pc_addr_o);
                end else begin
                    e   = exp_q.pop_front();
                    got = e.rvc ? {16'h0000, bus.inst_o[15:0]} : bus.inst_o;
                    if (bus.pc_addr_o !== e.pc || got !== e.inst) begin
                        n_bad++;
                        $display("FAIL sb_inst: got pc %h inst %h required pc %h inst %h",
                                 bus.pc_addr_o, got, e.pc, e.inst);
                    end
                    n_consumed++;
                    refill();
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        restart(RESET_PC);
        rst = 1'b1;
    endtask

    initial begin : stimulus
        logic [31:0] t, pc0, inst0;
        rst = 1'b1;
        bus.stall_i          = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h4505_4501;
        mem[1] = 32'h0513_4501;
        #2 rst = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        check("rst_pc",       bus.pc_addr_o,          RESET_PC);
        check("rst_req_addr", bus.icache_req_addr_o,  RESET_PC);
        check("rst_req_vld",  32'(bus.icache_req_valid_o), 32'd0);
        check("rst_inst",     bus.inst_o,             32'd0);
        check("rst_if_vld",   32'(bus.if_rdata_valid_o),   32'd0);
        check("rst_next_vld", 32'(bus.next_rdata_valid_o), 32'd0);

        // Boot: no request in the first cycle, then sequential word fetches
        lat_min = 0; lat_max = 0; ready_pct = 100;
        @(posedge clk); #1;
        restart(RESET_PC);
        req_log.delete();
        rst = 1'b1;
        @(negedge clk); #3;
        check("boot_no_req", 32'(bus.icache_req_valid_o), 32'd0);
        repeat (40) @(posedge clk);
        check("boot_req0", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h8000_0000);
        check("boot_req1", req_log.size() > 1 ? req_log[1] : 32'hFFFF_FFFF, 32'h8000_0004);

        // Redirect with two requests in flight: drain, then refetch from the aligned target
        lat_min = 8; lat_max = 8;
        do_reset();
        for (int k = 0; k < 30 && pend.size() < 2; k++) begin
            @(negedge clk); #3;
        end
        check("two_outstanding", 32'(pend.size()), 32'd2);
        @(posedge clk); #1;
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h8000_0102;
        restart(32'h8000_0102);
        req_log.delete();
        @(posedge clk); #1;
        bus.redirect_valid_i = 1'b0;
        lat_min = 0; lat_max = 2;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #3;
            if (pend.size() == 0) break;
            check("drain_no_req", 32'(bus.icache_req_valid_o), 32'd0);
        end
        for (int k = 0; k < 30 && req_log.size() == 0; k++) @(negedge clk);
        check("redir_req_addr", req_log.size() > 0 ? req_log[0] : 32'hFFFF_FFFF, 32'h8000_0100);
        repeat (30) @(posedge clk);

        // Random traffic: stalls, redirects (odd targets included), random ready and latency
        lat_min = 0; lat_max = 3; ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.stall_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                t = {20'h80000, 12'($urandom_range(0, 4095))};
                bus.redirect_valid_i = 1'b1;
                bus.redirect_pc_i    = t;
                restart(t);
            end else begin
                bus.redirect_valid_i = 1'b0;
            end
        end
        bus.redirect_valid_i = 1'b0;
        bus.stall_i          = 1'b0;

        // Long stall: window frozen, fetching stops once both slots are full
        lat_min = 0; lat_max = 0; ready_pct = 100;
        @(posedge clk); #1;
        bus.stall_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); #3;
        pc0   = bus.pc_addr_o;
        inst0 = bus.inst_o;
        check("stall_if_vld",   32'(bus.if_rdata_valid_o),   32'd1);
        check("stall_next_vld", 32'(bus.next_rdata_valid_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #3;
            check("stall_pc",   bus.pc_addr_o, pc0);
            check("stall_inst", bus.inst_o,    inst0);
        end
        check("stall_req_stop", 32'(bus.icache_req_valid_o), 32'd0);
        @(posedge clk); #1;
        bus.stall_i = 1'b0;
        repeat (20) @(posedge clk);

        // Asynchronous reset in the middle of a fetch
        lat_min = 5; lat_max = 5;
        repeat (10) @(posedge clk);
        for (int k = 0; k < 30 && pend.size() == 0; k++) begin
            @(negedge clk); #3;
        end
        check("mid_outstanding", 32'(pend.size() > 0), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_pc",       bus.pc_addr_o,         RESET_PC);
        check("arst_req_addr", bus.icache_req_addr_o, RESET_PC);
        check("arst_if_vld",   32'(bus.if_rdata_valid_o),   32'd0);
        check("arst_next_vld", 32'(bus.next_rdata_valid_o), 32'd0);
        check("arst_req_vld",  32'(bus.icache_req_valid_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        restart(RESET_PC);
        rst = 1'b1;
        @(negedge clk); #3;
        check("late_resp_dropped", 32'(bus.if_rdata_valid_o), 32'd0);
        lat_min = 0; lat_max = 3; ready_pct = 80;
        repeat (150) @(posedge clk);

        check("progress", 32'(n_consumed > 300), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
